// File: rtl/config_frame_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module   : config_frame_writer                                             |
// | Purpose  : Assembles one configuration frame from a 32-bit word stream     |
// |            (header + NUM_ROWS data words) and drives the fabric-wide       |
// |            FrameData rows plus a single FrameStrobe line of one column.    |
// | Ports    : UserCLK     - clock                                             |
// |            rst         - asynchronous reset, active-low                    |
// |            s_data      - stream word                                       |
// |            s_valid     - s_data valid                                      |
// |            s_ready     - writer can accept a word                          |
// |            FrameData   - row r = [r*FRAME_BITS_PER_ROW +: FRAME_BITS...]   |
// |            FrameStrobe - column c frame f = bit c*MAX_FRAMES_PER_COL+f     |
// |            busy        - FSM not idle                                      |
// |            err         - sticky error (bad header / checksum mismatch)     |
// |            frame_count - frames strobed since reset, saturating           |
// | Option   : CONFIG_FRAME_CHECKSUM_EN - adds a trailing checksum word that   |
// |            must equal the mod-2^32 sum of header and data words.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module config_frame_writer #(
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int NUM_ROWS           = 7,
    parameter int NUM_COLUMNS        = 23,
    parameter int STROBE_CYCLES      = 2
) (
    input  logic                                     UserCLK,
    input  logic                                     rst,
    input  logic [FRAME_BITS_PER_ROW-1:0]            s_data,
    input  logic                                     s_valid,
    output logic                                     s_ready,
    output logic [NUM_ROWS*FRAME_BITS_PER_ROW-1:0]   FrameData,
    output logic [NUM_COLUMNS*MAX_FRAMES_PER_COL-1:0] FrameStrobe,
    output logic                                     busy,
    output logic                                     err,
    output logic [15:0]                              frame_count
);

    localparam int c_ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int c_COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
    localparam int c_FRM_W = (MAX_FRAMES_PER_COL > 1) ? $clog2(MAX_FRAMES_PER_COL) : 1;
    localparam int c_STB_W = 4;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_STROBE = 3'd2;
    localparam logic [2:0] c_GAP    = 3'd3;
    localparam logic [2:0] c_SKIP   = 3'd4;
`ifdef CONFIG_FRAME_CHECKSUM_EN
    localparam logic [2:0] c_CHECK  = 3'd5;
`endif

    logic [2:0]                   r_state;
    logic [2:0]                   w_next_state;
    logic                         r_ready;
    logic [c_ROW_W-1:0]           r_row;
    logic [c_COL_W-1:0]           r_col;
    logic [c_FRM_W-1:0]           r_frame;
    logic [c_STB_W-1:0]           r_strobe_cnt;
    logic [15:0]                  r_frame_count;
    logic                         r_err;
    logic [FRAME_BITS_PER_ROW-1:0] r_rows [NUM_ROWS];
    logic [NUM_COLUMNS*MAX_FRAMES_PER_COL-1:0] r_frame_strobe;
    logic [NUM_COLUMNS*MAX_FRAMES_PER_COL-1:0] w_strobe_vec;

    logic w_xfer;
    logic w_last_row;
    logic w_hdr_ok;
    logic w_strobe_start;
    logic w_strobe_on;
    logic w_ready_next;
    logic w_sum_ok;

    assign w_xfer     = s_valid && r_ready;
    assign w_last_row = (r_row == c_ROW_W'(NUM_ROWS - 1));
    assign w_hdr_ok   = (s_data[31:24] == 8'hA5) &&
                        (s_data[23:16] < 8'(NUM_COLUMNS)) &&
                        (s_data[15:8]  < 8'(MAX_FRAMES_PER_COL));

`ifdef CONFIG_FRAME_CHECKSUM_EN
    // Running sum restarts with the header word itself.
    logic [FRAME_BITS_PER_ROW-1:0] r_sum;

    always_ff @(posedge UserCLK or negedge rst) begin
        if (!rst) begin
            r_sum <= '0;
        end else if (w_xfer && r_state == c_IDLE) begin
            r_sum <= s_data;
        end else if (w_xfer && r_state == c_LOAD) begin
            r_sum <= r_sum + s_data;
        end
    end

    assign w_sum_ok = (s_data == r_sum);
`else
    assign w_sum_ok = 1'b1;
`endif

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_xfer) w_next_state = w_hdr_ok ? c_LOAD : c_SKIP;
            end
            c_LOAD: begin
                if (w_xfer && w_last_row) begin
`ifdef CONFIG_FRAME_CHECKSUM_EN
                    w_next_state = c_CHECK;
`else
                    w_next_state = c_STROBE;
`endif
                end
            end
`ifdef CONFIG_FRAME_CHECKSUM_EN
            c_CHECK: begin
                if (w_xfer) w_next_state = w_sum_ok ? c_STROBE : c_IDLE;
            end
`endif
            c_STROBE: begin
                if (r_strobe_cnt == '0) w_next_state = c_GAP;
            end
            c_GAP: begin
                w_next_state = c_IDLE;
            end
            c_SKIP: begin
                if (w_xfer && w_last_row) w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Strobe and ready are registered from the next state so the fabric sees
    // glitch-free lines and reset can force both low asynchronously.
    assign w_strobe_on    = (w_next_state == c_STROBE);
    assign w_strobe_start = w_strobe_on && (r_state != c_STROBE);
    assign w_ready_next   = (w_next_state != c_STROBE) && (w_next_state != c_GAP);

    always_comb begin
        w_strobe_vec = '0;
        for (int c = 0; c < NUM_COLUMNS; c++) begin
            for (int f = 0; f < MAX_FRAMES_PER_COL; f++) begin
                w_strobe_vec[c*MAX_FRAMES_PER_COL + f] = w_strobe_on &&
                    (r_col == c_COL_W'(c)) && (r_frame == c_FRM_W'(f));
            end
        end
    end

    always_ff @(posedge UserCLK or negedge rst) begin
        if (!rst) begin
            r_state        <= c_IDLE;
            r_ready        <= 1'b0;
            r_row          <= '0;
            r_col          <= '0;
            r_frame        <= '0;
            r_strobe_cnt   <= '0;
            r_frame_count  <= '0;
            r_err          <= 1'b0;
            r_frame_strobe <= '0;
            for (int r = 0; r < NUM_ROWS; r++) r_rows[r] <= '0;
        end else begin
            r_state        <= w_next_state;
            r_ready        <= w_ready_next;
            r_frame_strobe <= w_strobe_vec;

            if (w_xfer && r_state == c_IDLE) begin
                r_row <= '0;
                if (w_hdr_ok) begin
                    r_col   <= s_data[16 +: c_COL_W];
                    r_frame <= s_data[8 +: c_FRM_W];
                end else begin
                    r_err <= 1'b1;
                end
            end else if (w_xfer && (r_state == c_LOAD || r_state == c_SKIP)) begin
                r_row <= r_row + c_ROW_W'(1);
            end

`ifdef CONFIG_FRAME_CHECKSUM_EN
            if (w_xfer && r_state == c_CHECK && !w_sum_ok) r_err <= 1'b1;
`endif

            for (int r = 0; r < NUM_ROWS; r++) begin
                if (w_xfer && r_state == c_LOAD && r_row == c_ROW_W'(r)) r_rows[r] <= s_data;
            end

            if (w_strobe_start) begin
                r_strobe_cnt <= c_STB_W'(STROBE_CYCLES - 1);
                if (r_frame_count != 16'hFFFF) r_frame_count <= r_frame_count + 16'd1;
            end else if (r_state == c_STROBE && r_strobe_cnt != '0) begin
                r_strobe_cnt <= r_strobe_cnt - c_STB_W'(1);
            end
        end
    end

    generate
        for (genvar r = 0; r < NUM_ROWS; r++) begin : g_rows
            assign FrameData[r*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] = r_rows[r];
        end
    endgenerate

    assign s_ready     = r_ready;
    assign FrameStrobe = r_frame_strobe;
    assign busy        = (r_state != c_IDLE);
    assign err         = r_err;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_config_frame_writer.sv
`default_nettype none
//------------------------------------------------------------------------------
// +----------------------------------------------------------------------------+
// | Module   : tb_config_frame_writer                                          |
// | Purpose  : Self-checking bench for config_frame_writer; a frame-level      |
// |            reference model predicts FrameData, strobes, err, frame_count.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_config_frame_writer;

    localparam int W  = 32;
    localparam int MF = 20;
    localparam int NR = 7;
    localparam int NC = 23;
    localparam int SC = 2;
    localparam int NS = NC * MF;
`ifdef CONFIG_FRAME_CHECKSUM_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    logic          UserCLK = 1'b0;
    logic          rst     = 1'b0;
    logic [W-1:0]  s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [NR*W-1:0] FrameData;
    logic [NS-1:0] FrameStrobe;
    logic          busy;
    logic          err;
    logic [15:0]   frame_count;

    config_frame_writer dut (
        .UserCLK    (UserCLK),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .busy       (busy),
        .err        (err),
        .frame_count(frame_count)
    );

    always #5 UserCLK = ~UserCLK;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state (frame level)
    logic [31:0] m_rows [NR];
    bit          m_err;
    int          m_count;
    int          exp_log[$];
    logic [31:0] tx_q[$];

    // Observation: one entry per cycle with any strobe high
    int obs_log[$];
    int obs_cyc[$];
    int multi_hot = 0;
    int ready_low = 0;
    int cyc = 0;

    always @(posedge UserCLK) begin
        int idx;
        #1;
        cyc++;
        if (FrameStrobe != '0) begin
            idx = -1;
            for (int i = 0; i < NS; i++) if (FrameStrobe[i]) idx = i;
            if ($countones(FrameStrobe) != 1) multi_hot++;
            obs_log.push_back(idx);
            obs_cyc.push_back(cyc);
        end
        if (!s_ready) ready_low++;
    end

    task clear_mon();
        obs_log.delete();
        obs_cyc.delete();
        exp_log.delete();
        multi_hot = 0;
        ready_low = 0;
    endtask

    task model_reset();
        for (int r = 0; r < NR; r++) m_rows[r] = '0;
        m_err   = 0;
        m_count = 0;
    endtask

    // Appends a frame's words to tx_q and applies its effect to the model.
    task build_frame(input logic [31:0] hdr, input logic [31:0] d [NR], input bit bad_sum);
        logic [31:0] sum;
        bit ok;
        bit strobe_ok;
        ok = (hdr[31:24] == 8'hA5) && (hdr[23:16] < NC) && (hdr[15:8] < MF);
        tx_q.push_back(hdr);
        sum = hdr;
        for (int r = 0; r < NR; r++) begin
            tx_q.push_back(d[r]);
            sum = sum + d[r];
        end
        if (!ok) begin
            m_err = 1;
        end else begin
            for (int r = 0; r < NR; r++) m_rows[r] = d[r];
`ifdef CONFIG_FRAME_CHECKSUM_EN
            tx_q.push_back(bad_sum ? sum + 32'd1 : sum);
`endif
            strobe_ok = !bad_sum;
            if (!strobe_ok) begin
                m_err = 1;
            end else begin
                if (m_count < 65535) m_count++;
                for (int k = 0; k < SC; k++) exp_log.push_back(hdr[23:16] * MF + hdr[15:8]);
            end
        end
    endtask

    // Streams tx_q; called and returns on a negedge.
    task drive(input bit gappy, input bit wait_idle);
        int idx;
        int budget;
        bit rdy;
        bit tog;
        idx = 0; budget = 0; tog = 0;
        while (idx < tx_q.size() && budget < 2000) begin
            if (gappy) begin
                tog = !tog;
                s_valid = tog;
            end else begin
                s_valid = 1'b1;
            end
            s_data = tx_q[idx];
            rdy = s_ready;
            @(posedge UserCLK);
            if (s_valid && rdy) idx++;
            @(negedge UserCLK);
            budget++;
        end
        s_valid = 1'b0;
        n_checks++;
        if (idx != tx_q.size()) begin
            n_errs++;
            $display("FAIL drive_timeout: consumed %0d words, required %0d", idx, tx_q.size());
        end
        tx_q.delete();
        if (wait_idle) begin
            budget = 0;
            while (busy && budget < 100) begin
                @(negedge UserCLK);
                budget++;
            end
            n_checks++;
            if (busy) begin
                n_errs++;
                $display("FAIL idle_timeout: busy=%0b required 0", busy);
            end
        end
    endtask

    task test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge UserCLK);
        n_checks++; if (FrameData !== '0) begin n_errs++; $display("FAIL rst_framedata: got %h required 0", FrameData); end
        n_checks++; if (FrameStrobe !== '0) begin n_errs++; $display("FAIL rst_strobe: got %h required 0", FrameStrobe); end
        n_checks++; if (s_ready !== 1'b0) begin n_errs++; $display("FAIL rst_ready: got %b required 0", s_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL rst_err: got %b required 0", err); end
        n_checks++; if (frame_count !== 16'd0) begin n_errs++; $display("FAIL rst_count: got %0d required 0", frame_count); end
        rst = 1'b1;
        @(negedge UserCLK);
        n_checks++; if (s_ready !== 1'b1) begin n_errs++; $display("FAIL rst_release_ready: got %b required 1", s_ready); end
    endtask

    task test_valid_frame();
        logic [31:0] d [NR];
        for (int r = 0; r < NR; r++) d[r] = r + 1;
        clear_mon();
        build_frame(32'hA503_0500, d, 0);
        drive(0, 1);
        for (int r = 0; r < NR; r++) begin
            n_checks++;
            if (FrameData[r*W +: W] !== r + 1) begin
                n_errs++; $display("FAIL valid_row%0d: got %h required %h", r, FrameData[r*W +: W], r + 1);
            end
        end
        n_checks++;
        if (obs_log.size() != 2 || obs_log[0] != 65 || obs_log[1] != 65 || obs_cyc[1] - obs_cyc[0] != 1) begin
            n_errs++; $display("FAIL valid_strobe: got %0d strobe cycles, required 2 consecutive on bit 65", obs_log.size());
        end
        n_checks++; if (multi_hot != 0) begin n_errs++; $display("FAIL valid_onehot: got %0d multi-hot cycles required 0", multi_hot); end
        n_checks++; if (frame_count !== 16'd1) begin n_errs++; $display("FAIL valid_count: got %0d required 1", frame_count); end
        n_checks++; if (ready_low != SC + 1) begin n_errs++; $display("FAIL valid_ready_low: got %0d cycles required %0d", ready_low, SC + 1); end
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL valid_err: got %b required 0", err); end
    endtask

    task test_bad_column();
        logic [31:0] d [NR];
        int col;
        int frm;
        for (int r = 0; r < NR; r++) d[r] = $urandom;
        clear_mon();
        build_frame(32'hA517_0000, d, 0);
        drive(0, 1);
        n_checks++; if (err !== 1'b1) begin n_errs++; $display("FAIL badcol_err: got %b required 1", err); end
        n_checks++; if (obs_log.size() != 0) begin n_errs++; $display("FAIL badcol_strobe: got %0d strobe cycles required 0", obs_log.size()); end
        for (int r = 0; r < NR; r++) begin
            n_checks++;
            if (FrameData[r*W +: W] !== m_rows[r]) begin
                n_errs++; $display("FAIL badcol_row%0d: got %h required %h", r, FrameData[r*W +: W], m_rows[r]);
            end
        end
        col = $urandom_range(0, NC - 1);
        frm = $urandom_range(0, MF - 1);
        for (int r = 0; r < NR; r++) d[r] = $urandom;
        clear_mon();
        build_frame({8'hA5, 8'(col), 8'(frm), 8'h5A}, d, 0);
        drive(0, 1);
        n_checks++;
        if (obs_log != exp_log) begin
            n_errs++; $display("FAIL badcol_next_strobe: got %0d strobe cycles required %0d on bit %0d", obs_log.size(), SC, col * MF + frm);
        end
        n_checks++; if (err !== 1'b1) begin n_errs++; $display("FAIL badcol_err_sticky: got %b required 1", err); end
        n_checks++; if (frame_count !== 16'(m_count)) begin n_errs++; $display("FAIL badcol_count: got %0d required %0d", frame_count, m_count); end
    endtask

    task test_backpressure();
        logic [31:0] d [NR];
        for (int r = 0; r < NR; r++) d[r] = r + 1;
        clear_mon();
        build_frame(32'hA503_0500, d, 0);
        drive(1, 1);
        for (int r = 0; r < NR; r++) begin
            n_checks++;
            if (FrameData[r*W +: W] !== r + 1) begin
                n_errs++; $display("FAIL bp_row%0d: got %h required %h", r, FrameData[r*W +: W], r + 1);
            end
        end
        n_checks++;
        if (obs_log.size() != 2 || obs_log[0] != 65 || obs_log[1] != 65) begin
            n_errs++; $display("FAIL bp_strobe: got %0d strobe cycles required 2 on bit 65", obs_log.size());
        end
        n_checks++; if (frame_count !== 16'(m_count)) begin n_errs++; $display("FAIL bp_count: got %0d required %0d", frame_count, m_count); end
    endtask

    task test_back_to_back();
        logic [31:0] d [NR];
        int c0;
        clear_mon();
        c0 = m_count;
        for (int r = 0; r < NR; r++) d[r] = $urandom;
        build_frame(32'hA500_0000, d, 0);
        for (int r = 0; r < NR; r++) d[r] = $urandom;
        build_frame(32'hA516_1300, d, 0);
        drive(0, 1);
        n_checks++;
        if (obs_log.size() != 4 || obs_log[0] != 0 || obs_log[1] != 0 || obs_log[2] != 459 || obs_log[3] != 459) begin
            n_errs++; $display("FAIL b2b_strobe_order: got %0d strobe cycles required 0,0,459,459", obs_log.size());
        end else begin
            n_checks++;
            if (obs_cyc[2] - obs_cyc[0] != SC + 1 + 1 + NR + XTRA) begin
                n_errs++; $display("FAIL b2b_spacing: got %0d cycles required %0d", obs_cyc[2] - obs_cyc[0], SC + 2 + NR + XTRA);
            end
        end
        n_checks++; if (frame_count !== 16'(c0 + 2)) begin n_errs++; $display("FAIL b2b_count: got %0d required %0d", frame_count, c0 + 2); end
        for (int r = 0; r < NR; r++) begin
            n_checks++;
            if (FrameData[r*W +: W] !== m_rows[r]) begin
                n_errs++; $display("FAIL b2b_row%0d: got %h required %h", r, FrameData[r*W +: W], m_rows[r]);
            end
        end
    endtask

    task test_random();
        logic [31:0] d [NR];
        logic [31:0] hdr;
        int kind;
        for (int n = 0; n < 8; n++) begin
            clear_mon();
            for (int r = 0; r < NR; r++) d[r] = $urandom;
            kind = $urandom_range(0, 5);
            hdr = {8'hA5, 8'($urandom_range(0, NC - 1)), 8'($urandom_range(0, MF - 1)), 8'($urandom)};
            if (kind == 0) hdr[31:24] = 8'($urandom_range(0, 164));
            if (kind == 1) hdr[23:16] = 8'($urandom_range(NC, 255));
            if (kind == 2) hdr[15:8]  = 8'($urandom_range(MF, 255));
            build_frame(hdr, d, 0);
            drive(1'($urandom_range(0, 1)), 1);
            n_checks++;
            if (obs_log != exp_log || multi_hot != 0) begin
                n_errs++; $display("FAIL rand%0d_strobe: got %0d strobe cycles required %0d (hdr %h)", n, obs_log.size(), exp_log.size(), hdr);
            end
            n_checks++; if (err !== m_err) begin n_errs++; $display("FAIL rand%0d_err: got %b required %b", n, err, m_err); end
            n_checks++; if (frame_count !== 16'(m_count)) begin n_errs++; $display("FAIL rand%0d_count: got %0d required %0d", n, frame_count, m_count); end
            for (int r = 0; r < NR; r++) begin
                n_checks++;
                if (FrameData[r*W +: W] !== m_rows[r]) begin
                    n_errs++; $display("FAIL rand%0d_row%0d: got %h required %h", n, r, FrameData[r*W +: W], m_rows[r]);
                end
            end
        end
    endtask

`ifdef CONFIG_FRAME_CHECKSUM_EN
    task test_checksum();
        logic [31:0] d [NR];
        int c0;
        for (int r = 0; r < NR; r++) d[r] = $urandom;
        clear_mon();
        build_frame(32'hA507_0900, d, 0);
        drive(0, 1);
        n_checks++;
        if (obs_log != exp_log || obs_log.size() != SC) begin
            n_errs++; $display("FAIL cks_good_strobe: got %0d strobe cycles required %0d on bit %0d", obs_log.size(), SC, 7 * MF + 9);
        end
        c0 = m_count;
        n_checks++; if (frame_count !== 16'(c0)) begin n_errs++; $display("FAIL cks_good_count: got %0d required %0d", frame_count, c0); end
        clear_mon();
        build_frame(32'hA507_0900, d, 1);
        drive(0, 1);
        n_checks++; if (obs_log.size() != 0) begin n_errs++; $display("FAIL cks_bad_strobe: got %0d strobe cycles required 0", obs_log.size()); end
        n_checks++; if (err !== 1'b1) begin n_errs++; $display("FAIL cks_bad_err: got %b required 1", err); end
        n_checks++; if (frame_count !== 16'(c0)) begin n_errs++; $display("FAIL cks_bad_count: got %0d required %0d", frame_count, c0); end
        for (int r = 0; r < NR; r++) begin
            n_checks++;
            if (FrameData[r*W +: W] !== d[r]) begin
                n_errs++; $display("FAIL cks_bad_row%0d: got %h required %h", r, FrameData[r*W +: W], d[r]);
            end
        end
    endtask
`endif

    task test_reset_mid_strobe();
        logic [31:0] d [NR];
        for (int r = 0; r < NR; r++) d[r] = $urandom;
        clear_mon();
        build_frame(32'hA50A_0400, d, 0);
        drive(0, 0);
        // Now in the first strobe cycle.
        n_checks++; if (FrameStrobe[10*MF+4] !== 1'b1) begin n_errs++; $display("FAIL mid_strobe_pre: got %b required 1", FrameStrobe[10*MF+4]); end
        rst = 1'b0;
        #1;
        n_checks++; if (FrameStrobe !== '0) begin n_errs++; $display("FAIL mid_strobe_async: got %h required 0", FrameStrobe); end
        model_reset();
        @(negedge UserCLK);
        rst = 1'b1;
        @(negedge UserCLK);
        n_checks++; if (s_ready !== 1'b1) begin n_errs++; $display("FAIL mid_ready: got %b required 1", s_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errs++; $display("FAIL mid_busy: got %b required 0", busy); end
        n_checks++; if (frame_count !== 16'd0) begin n_errs++; $display("FAIL mid_count: got %0d required 0", frame_count); end
        n_checks++; if (FrameStrobe !== '0) begin n_errs++; $display("FAIL mid_strobe_after: got %h required 0", FrameStrobe); end
        n_checks++; if (err !== 1'b0) begin n_errs++; $display("FAIL mid_err: got %b required 0", err); end
    endtask

    initial begin
        @(negedge UserCLK);
        test_reset();
        test_valid_frame();
        test_bad_column();
        test_backpressure();
        test_back_to_back();
        test_random();
`ifdef CONFIG_FRAME_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_strobe();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Configuration-side counterpart to the per-tile ConfigMem latches: accepts a 32-bit word stream, assembles one configuration frame, and drives the fabric-wide FrameData rows plus one FrameStrobe line of one column.
- Sits between the bitstream source (SPI/UART loader) and the tile array; FrameData/FrameStrobe outputs feed the first tile of each row/column daisy chain.

Parameters:
- FrameBitsPerRow, 32, FrameData bits per fabric row (equals stream word width)
- MaxFramesPerCol, 20, FrameStrobe lines per column
- NumRows, 7, fabric rows, i.e. data words per frame
- NumColumns, 23, fabric columns
- StrobeCycles, 2, cycles FrameStrobe is held high (1..15)

Ports:
- UserCLK  in  1  clock
- rst  in  1  asynchronous reset, active-low
- s_data  in  FrameBitsPerRow  stream word
- s_valid  in  1  s_data valid
- s_ready  out  1  writer can accept a word
- FrameData  out  NumRows*FrameBitsPerRow  row data; row r = bits [r*FrameBitsPerRow +: FrameBitsPerRow]
- FrameStrobe  out  NumColumns*MaxFramesPerCol  column c frame f = bit c*MaxFramesPerCol+f
- busy  out  1  state != IDLE
- err  out  1  sticky error flag
- frame_count  out  16  frames strobed since reset, saturating at 0xFFFF

Behaviour:
- Transfer occurs on a rising UserCLK edge when s_valid && s_ready. The source must hold s_data stable while s_valid && !s_ready.
- Reset (rst=0, asynchronous): state IDLE, FrameData=0, FrameStrobe=0, s_ready=0 during reset, err=0, frame_count=0, busy=0.
- Header word: [31:24]=0xA5 sync, [23:16]=column, [15:8]=frame index, [7:0]=reserved (ignored).
- IDLE: s_ready=1. On a header transfer:
  - valid header (sync==0xA5, column<NumColumns, frame<MaxFramesPerCol): latch column/frame, row counter=0, go LOAD.
  - otherwise: set err, go SKIP.
- LOAD: s_ready=1. Each transfer writes the word to FrameData row[row counter] and increments the counter. The transfer at counter==NumRows-1 goes to STROBE (or CHECK when the option is enabled).
  - Rows are updated in place; FrameStrobe stays 0 throughout LOAD.
- STROBE: s_ready=0. FrameStrobe bit (column*MaxFramesPerCol+frame) is high for exactly StrobeCycles cycles; all other bits are 0. The first strobe cycle is the cycle after the last data transfer. frame_count increments once on entry. Then go GAP.
- GAP: s_ready=0, all strobes 0, FrameData unchanged for 1 cycle (latch hold time). Then go IDLE.
- SKIP: s_ready=1. Consume and discard NumRows words. FrameData and FrameStrobe are untouched. Then go IDLE.
- FrameData is never cleared between frames; it holds the last loaded value.
- err clears only on reset.
- s_valid low mid-frame: the FSM waits indefinitely in its current state; there is no timeout.
- Reset asserted mid-frame: FrameStrobe drops to 0 immediately (asynchronously) and the partial frame is discarded.
- Minimum frame latency: 1 + NumRows transfers, then StrobeCycles + 1 cycles before s_ready returns high.

Optional Feature:
- Macro CONFIG_FRAME_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum (mod 2^32) covers the header and all NumRows data words.
  - After the last data word, state CHECK (s_ready=1) accepts one checksum word.
  - Match: go STROBE.
  - Mismatch: set err, no strobe, frame_count unchanged, go IDLE. FrameData keeps the loaded (unstrobed) data.
  - The sum resets on every header.
- Undefined: no CHECK state, no checksum word in the stream, and no checksum logic is synthesised.

Test Plan:
- Valid frame: header 0xA5_03_05_00, rows 0x00000001..0x00000007, s_valid held high -> FrameData row r = r+1; FrameStrobe bit 3*20+5=65 high exactly 2 cycles; frame_count=1; s_ready low 3 cycles; err=0.
- Bad column: header 0xA5_17_00_00 (column 23) + 7 words -> err=1, no FrameStrobe bit ever high, FrameData unchanged; next valid frame strobes normally and err stays 1.
- Backpressure/gaps: valid frame with s_valid toggled every other cycle -> same FrameData/strobe result as the first case; no word is lost or duplicated.
- Reset mid-strobe: assert rst during the first strobe cycle -> FrameStrobe=0 immediately; after release state is IDLE, frame_count=0, s_ready=1.
- Back-to-back frames: (col 0, frame 0), then (col 22, frame 19) -> strobe bits 0 then 459, separated by the GAP cycle; frame_count=2.
- CONFIG_FRAME_CHECKSUM_EN: valid frame with correct sum -> strobe; same frame with sum+1 -> err=1, no strobe, frame_count unchanged.
